// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment driver: 8x3-bit character buffer with rotate,
// active-low segment decode, one-hot-low anode scan with a blanking gap per slot.
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [2:0] char_in,
  input  logic       shift_en,
  output logic [0:6] HEX0,
  output logic [7:0] AN,
  output logic       frame_tick
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt;
  logic [2:0]    k;
  logic [2:0]    char_buf [8];
  logic [2:0]    buf_next [8];
  logic [7:0]    an_next;
  logic [0:6]    hex_next;
  logic          tick_next;
  logic          cnt_wrap;

  // Segment order a..g from left to right, 0 = segment lit.
  function automatic logic [0:6] seg(input logic [2:0] code);
    case (code)
      3'd0:    seg = 7'b1000010;  // d
      3'd1:    seg = 7'b0110000;  // E
      3'd2:    seg = 7'b1001111;  // 1
      3'd3:    seg = 7'b0000001;  // 0
      default: seg = 7'b1111111;
    endcase
  endfunction

  // wr_en and shift_en have no handshake: both are taken on every edge they are high.
  // With both high, the rotation happens first and the write then overrides one entry.
  always_comb begin
    for (int i = 0; i < 8; i++) buf_next[i] = char_buf[i];
    if (shift_en) begin
      for (int i = 0; i < 8; i++) buf_next[i] = char_buf[3'(i - 1)];
    end
    if (wr_en) buf_next[wr_addr] = char_in;
  end

  assign cnt_wrap = (cnt == CNT_LAST);

  always_comb begin
    an_next   = 8'hFF;
    hex_next  = 7'b1111111;
    tick_next = cnt_wrap && (k == 3'd7);
    if (cnt >= CNT_BLANK) begin
      an_next  = ~(8'b1 << k);
      hex_next = seg(char_buf[k]);
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      cnt        <= '0;
      k          <= 3'd0;
      for (int i = 0; i < 8; i++) char_buf[i] <= 3'b111;
      AN         <= 8'hFF;
      HEX0       <= 7'b1111111;
      frame_tick <= 1'b0;
    end else begin
      cnt <= cnt_wrap ? '0 : cnt + 1'b1;
      if (cnt_wrap) k <= k + 3'd1;
      for (int i = 0; i < 8; i++) char_buf[i] <= buf_next[i];
      AN         <= an_next;
      HEX0       <= hex_next;
      frame_tick <= tick_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4, BLANK_CYCLES=1:
// decode table, rotation, shift+write, frame tick spacing and mid-scan reset.
module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [2:0] char_in = 3'd0;
  logic       shift_en = 1'b0;
  logic [0:6] hex;
  logic [7:0] an;
  logic       frame_tick;

  int total = 0;
  int bad = 0;

  logic [2:0] exp_buf [8];

  typedef struct {
    logic [2:0] addr;
    logic [2:0] code;
    logic [7:0] an;
    logic [6:0] hex;
  } vec_t;

  vec_t vecs [4];

  seg7_scan_driver #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .char_in   (char_in),
    .shift_en  (shift_en),
    .HEX0      (hex),
    .AN        (an),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_ref(input logic [2:0] code);
    case (code)
      3'd0:    return 7'b1000010;
      3'd1:    return 7'b0110000;
      3'd2:    return 7'b1001111;
      3'd3:    return 7'b0000001;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic write_char(input logic [2:0] addr, input logic [2:0] code);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = addr; char_in = code;
    @(negedge clk);
    wr_en = 1'b0;
    exp_buf[addr] = code;
  endtask

  task automatic model_rotate();
    logic [2:0] t [8];
    for (int i = 0; i < 8; i++) t[i] = exp_buf[(i + 7) % 8];
    for (int i = 0; i < 8; i++) exp_buf[i] = t[i];
  endtask

  task automatic shift_n(input int n);
    @(negedge clk);
    shift_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      model_rotate();
    end
    shift_en = 1'b0;
  endtask

  task automatic wait_an(input logic [7:0] target, output logic found);
    found = 1'b0;
    for (int n = 0; n < 64 && !found; n++) begin
      @(negedge clk);
      if (an === target) found = 1'b1;
    end
    check("wait_an_timeout", {7'd0, found}, 8'd1);
  endtask

  // One full frame: every lit cycle must be one-hot-low and show the model's character.
  task automatic check_display(input string name);
    int lit;
    int d;
    lit = 0;
    for (int n = 0; n < 32; n++) begin
      @(negedge clk);
      if (an !== 8'hFF) begin
        lit++;
        check({name, "_onehot"}, 8'($countones(~an)), 8'd1);
        d = 0;
        for (int b = 0; b < 8; b++) if (an[b] == 1'b0) d = b;
        check({name, "_hex"}, {1'b0, hex}, {1'b0, seg_ref(exp_buf[d])});
      end
    end
    check({name, "_lit_count"}, 8'(lit), 8'd24);
  endtask

  initial begin
    logic found;
    logic [7:0] exp_an;
    int ft_cnt, ft_pos0, ft_pos1, ff_cnt, ff_adj;
    logic prev_ff;

    vecs[0] = '{addr: 3'd3, code: 3'd0, an: 8'hF7, hex: 7'b1000010};
    vecs[1] = '{addr: 3'd2, code: 3'd1, an: 8'hFB, hex: 7'b0110000};
    vecs[2] = '{addr: 3'd1, code: 3'd2, an: 8'hFD, hex: 7'b1001111};
    vecs[3] = '{addr: 3'd0, code: 3'd3, an: 8'hFE, hex: 7'b0000001};
    for (int i = 0; i < 8; i++) exp_buf[i] = 3'b111;

    // Reset held for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_an", an, 8'hFF);
      check("reset_hex", {1'b0, hex}, 8'h7F);
      check("reset_tick", {7'd0, frame_tick}, 8'd0);
    end
    rst_n = 1'b1;

    // First frame after release: 1 blank then 3 lit cycles per slot.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      exp_an = (i % 4 == 0) ? 8'hFF : ~(8'd1 << (i / 4));
      check("scan_an", an, exp_an);
      check("scan_hex_blank", {1'b0, hex}, 8'h7F);
      check("scan_tick", {7'd0, frame_tick}, (i == 31) ? 8'd1 : 8'd0);
    end

    // Decode table.
    for (int i = 0; i < 4; i++) write_char(vecs[i].addr, vecs[i].code);
    for (int i = 0; i < 4; i++) begin
      wait_an(vecs[i].an, found);
      check("decode_hex", {1'b0, hex}, {1'b0, vecs[i].hex});
    end
    check_display("decode");

    // Single rotation.
    shift_n(1);
    wait_an(8'hFD, found);
    check("rot_entry1", {1'b0, hex}, {1'b0, 7'b0000001});
    wait_an(8'hEF, found);
    check("rot_entry4", {1'b0, hex}, {1'b0, 7'b1000010});
    wait_an(8'hFE, found);
    check("rot_entry0", {1'b0, hex}, 8'h7F);
    check_display("rot1");

    // Seven more back-to-back shifts bring the original layout back.
    shift_n(7);
    check_display("rot8");
    for (int i = 0; i < 4; i++) check("rot8_model", {5'd0, exp_buf[vecs[i].addr]}, {5'd0, vecs[i].code});

    // Shift and write on the same edge.
    @(negedge clk);
    shift_en = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; char_in = 3'b001;
    @(negedge clk);
    shift_en = 1'b0; wr_en = 1'b0;
    model_rotate();
    exp_buf[0] = 3'b001;
    wait_an(8'hFE, found);
    check("shwr_entry0", {1'b0, hex}, {1'b0, 7'b0110000});
    check_display("shift_write");

    // Frame tick spacing and blank cycle per slot over 64 cycles.
    ft_cnt = 0; ft_pos0 = -1; ft_pos1 = -1; ff_cnt = 0; ff_adj = 0; prev_ff = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (frame_tick) begin
        if (ft_cnt == 0) ft_pos0 = i;
        else if (ft_cnt == 1) ft_pos1 = i;
        ft_cnt++;
      end
      if (an === 8'hFF) begin
        ff_cnt++;
        if (prev_ff) ff_adj++;
      end
      prev_ff = (an === 8'hFF);
    end
    check("tick_count", 8'(ft_cnt), 8'd2);
    check("tick_gap", 8'(ft_pos1 - ft_pos0), 8'd32);
    check("blank_count", 8'(ff_cnt), 8'd16);
    check("blank_adjacent", 8'(ff_adj), 8'd0);

    // Asynchronous reset in the middle of digit 4.
    wait_an(8'hEF, found);
    #2 rst_n = 1'b0;
    #1;
    check("async_an", an, 8'hFF);
    check("async_hex", {1'b0, hex}, 8'h7F);
    check("async_tick", {7'd0, frame_tick}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) exp_buf[i] = 3'b111;
    found = 1'b0;
    for (int n = 0; n < 12 && !found; n++) begin
      @(negedge clk);
      if (an !== 8'hFF) found = 1'b1;
    end
    check("post_reset_first_an", an, 8'hFE);
    check_display("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Eight-digit, time-multiplexed seven-segment driver for the board display, sitting directly downstream of the 3-bit character counter/shifter stage. It holds an 8-entry buffer of 3-bit character codes, rotates it on request, decodes each code to active-low segments, and scans the anodes one digit at a time with a ghost-blanking gap. A one-cycle frame pulse lets the upstream stage synchronise its updates to scan boundaries.

## Interface

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot. Must be at least 2.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off. Must be less than REFRESH_DIV.

Ports:
- CLK100MHZ  in  1  system clock, 100 MHz, rising-edge.
- CPU_RESETN  in  1  reset, asynchronous, active-low.
- wr_en  in  1  write char_in into buffer[wr_addr] at this edge.
- wr_addr  in  3  buffer entry to write; 0 is the rightmost digit, AN[0].
- char_in  in  3  character code to write.
- shift_en  in  1  rotate the buffer by one place at this edge.
- HEX0  out  [0:6]  segments a..g, active-low; HEX0[0] is a.
- AN  out  8  anodes, active-low, one-hot-low when a digit is lit.
- frame_tick  out  1  one-cycle pulse when the scan index wraps from 7 to 0.

## Operation

- Character map for codes 0–3: 000 = 'd' (b,c,d,e,g); 001 = 'E' (a,d,e,f,g); 010 = '1' (b,c); 011 = '0' (a–f). Codes 100–111 are blank, with all segments off.
- Buffer: 8 × 3 bits. Reset value 3'b111 (blank) in every entry.
- Shift: on shift_en, each entry takes the value of the entry below it (buf[i] <= buf[i-1]), and buf[0] <= buf[7]. This is a left rotation on the display.
- Simultaneous shift_en and wr_en: the rotation is applied first. The write then overrides the rotated value at wr_addr. The net effect on other entries is the pure rotation.
- Scan counter cnt: runs 0..REFRESH_DIV-1 and wraps to 0. On wrap, the 3-bit index k increments modulo 8.
- Ghost blanking: while cnt < BLANK_CYCLES, the output register loads AN = 8'hFF and HEX0 = 7'b1111111.
- Active display: otherwise the output register loads AN = ~(8'b1 << k) and HEX0 = seg(buf[k]).
- frame_tick: the registered output is 1 for exactly the one cycle following the edge at which k goes from 7 to 0. It is 0 otherwise.
- Reset, including an assertion in the middle of a scan, asynchronously forces the following values:
  - cnt = 0, k = 0
  - buffer all 3'b111
  - AN = 8'hFF, HEX0 = 7'b1111111, frame_tick = 0

  After CPU_RESETN deasserts, the scan starts from slot 0 with its blank phase.

## Timing

- All outputs are registered, with a latency of 1 cycle from the cnt/k/buffer state to the pins.
- A buffer write or shift at edge t is visible on HEX0 at edge t+1 if the affected digit is the active one and outside blanking.
- Slot length is exactly REFRESH_DIV cycles. The lit portion is REFRESH_DIV - BLANK_CYCLES cycles. One frame is 8 × REFRESH_DIV cycles.
- frame_tick period is 8 × REFRESH_DIV cycles.
- Exactly one AN bit is low at any time outside blanking. No two digits are ever lit in the same cycle.
- No handshake back-pressure: wr_en and shift_en are accepted on every cycle. Back-to-back shifts rotate once per cycle.

## Test plan

All scenarios use REFRESH_DIV = 4 and BLANK_CYCLES = 1.

1. **Reset:** Hold CPU_RESETN = 0 for 3 cycles, then release. Required: AN = 8'hFF and HEX0 = 7'b1111111 during reset. Afterwards, AN cycles FE, FD, …, 7F with 1 blank cycle per 4. HEX0 stays 7'b1111111, because all entries are blank.
2. **Decode:** Write codes 0,1,2,3 to entries 3,2,1,0. Required, while the corresponding anode is low:
   - AN = FE: HEX0 = 7'b0000001 ('0')
   - AN = FD: HEX0 = 7'b1001111 ('1')
   - AN = FB: HEX0 = 7'b0110000 ('E')
   - AN = F7: HEX0 = 7'b1000010 ('d')
3. **Rotation:** From scenario 2, pulse shift_en once. Required: entry 1 shows '0', entry 4 shows 'd', entry 0 is blank. After 8 total pulses, the contents match scenario 2 again.
4. **Simultaneous shift and write:** Assert shift_en and wr_en (wr_addr = 0, char_in = 3'b001) on the same cycle. Required: entry 0 = 'E', all other entries equal the pure rotation.
5. **Frame tick and blanking:** Over 64 cycles, frame_tick pulses exactly twice, 32 cycles apart. Every slot begins with exactly 1 cycle of AN = 8'hFF.
6. **Mid-scan reset:** Assert CPU_RESETN = 0 asynchronously while AN = 8'hEF. Required: AN = 8'hFF immediately, without waiting for a clock edge. After release, the buffer is all blank and the first lit anode is FE.
